// File: rtl/axis_header_insert_realign.sv
// Prepends a 0..W byte header to each AXI-Stream packet and repacks the
// payload so every beat but the last is full; single registered output stage.
module axis_header_insert_realign #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    typedef enum logic [1:0] {IDLE, PASS, TAIL} state_t;

    localparam logic [BYTE_CNT_WD:0] W_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    state_t                  state, state_nx;
    logic [DATA_WD-1:0]      res, res_nx;
    logic [BYTE_CNT_WD-1:0]  r_cnt, r_nx;
    logic                    valid_nx, last_nx;
    logic [DATA_WD-1:0]      data_nx;
    logic [DATA_BYTE_WD-1:0] keep_nx;

    logic                    ld_en;
    logic [BYTE_CNT_WD-1:0]  n_hdr, m_pay;
    logic [DATA_BYTE_WD-1:0] eff_keep;
    logic [DATA_WD-1:0]      pay;
    logic [2*DATA_WD-1:0]    cat;
    logic [BYTE_CNT_WD:0]    sum;
    int                      sh_r, sh_h;

    function automatic logic [BYTE_CNT_WD-1:0] popcnt(
        input logic [DATA_BYTE_WD-1:0] k
    );
        popcnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            popcnt = popcnt + BYTE_CNT_WD'(k[i]);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] kmask(
        input logic [BYTE_CNT_WD:0] c
    );
        kmask = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < int'(c)) kmask[DATA_BYTE_WD-1-i] = 1'b1;
    endfunction

    assign ld_en = !valid_out || ready_out;

    // Residual bytes live MSB-anchored in res with zeros below them,
    // so a beat is just res OR'd with the payload shifted down R bytes.
    always_comb begin
        eff_keep = last_in ? keep_in : '1;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            pay[i*8 +: 8] = data_in[i*8 +: 8] & {8{eff_keep[i]}};
        m_pay = popcnt(eff_keep);
        n_hdr = popcnt(keep_insert);
        sum   = {1'b0, r_cnt} + {1'b0, m_pay};
        sh_r  = int'(r_cnt) * 8;
        sh_h  = (DATA_BYTE_WD - int'(n_hdr)) * 8;
        cat   = {res, {DATA_WD{1'b0}}} | ({pay, {DATA_WD{1'b0}}} >> sh_r);
    end

    always_comb begin
        state_nx     = state;
        res_nx       = res;
        r_nx         = r_cnt;
        valid_nx     = valid_out && !ready_out;
        data_nx      = data_out;
        keep_nx      = keep_out;
        last_nx      = last_out;
        ready_insert = rst_n && (state == IDLE) && ld_en;
        ready_in     = rst_n && (state == PASS) && ld_en;
        unique case (state)
            IDLE: begin
                if (valid_insert && ready_insert) begin
                    res_nx   = data_insert << sh_h;
                    r_nx     = n_hdr;
                    state_nx = PASS;
                end
            end
            PASS: begin
                if (valid_in && ready_in) begin
                    valid_nx = 1'b1;
                    data_nx  = cat[2*DATA_WD-1 -: DATA_WD];
                    res_nx   = cat[DATA_WD-1:0];
                    keep_nx  = '1;
                    last_nx  = 1'b0;
                    if (last_in) begin
                        if (sum <= W_CNT) begin
                            keep_nx  = kmask(sum);
                            last_nx  = 1'b1;
                            r_nx     = '0;
                            res_nx   = '0;
                            state_nx = IDLE;
                        end else begin
                            r_nx     = BYTE_CNT_WD'(sum - W_CNT);
                            state_nx = TAIL;
                        end
                    end
                end
            end
            TAIL: begin
                if (ld_en) begin
                    valid_nx = 1'b1;
                    data_nx  = res;
                    keep_nx  = kmask({1'b0, r_cnt});
                    last_nx  = 1'b1;
                    r_nx     = '0;
                    res_nx   = '0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res       <= '0;
            r_cnt     <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            state     <= state_nx;
            res       <= res_nx;
            r_cnt     <= r_nx;
            valid_out <= valid_nx;
            data_out  <= data_nx;
            keep_out  <= keep_nx;
            last_out  <= last_nx;
        end
    end

endmodule

// File: tb/tb_axis_header_insert_realign.sv
// Scoreboard bench for axis_header_insert_realign at W=4: directed packets,
// random packets under output backpressure, and a mid-packet reset.
module tb_axis_header_insert_realign;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_insert = 1'b0;
    logic [31:0] data_insert = '0;
    logic [3:0]  keep_insert = '0;
    logic        ready_insert;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;

    beat_t       expq[$];
    beat_t       e, prev;
    logic        stalled = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          rmode = 0;
    logic [31:0] pd[16];
    logic [3:0]  pk[16];

    axis_header_insert_realign dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .valid_insert(valid_insert), .data_insert(data_insert),
        .keep_insert(keep_insert), .ready_insert(ready_insert),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
        .last_out(last_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (rmode == 0) ready_out = 1'b1;
        else if (rmode == 1) ready_out = 1'($urandom_range(0, 1));
        else ready_out = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!valid_out || {data_out, keep_out, last_out} != prev) begin
                    errors++;
                    $display("FAIL stable: got v=%0b %h/%b/%b required %h/%b/%b",
                             valid_out, data_out, keep_out, last_out,
                             prev.d, prev.k, prev.l);
                end
            end
            if (valid_out && ready_out) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h/%b/%b required none",
                             data_out, keep_out, last_out);
                end else begin
                    e = expq.pop_front();
                    if ({data_out, keep_out, last_out} != e) begin
                        errors++;
                        $display("FAIL beat: got %h/%b/%b required %h/%b/%b",
                                 data_out, keep_out, last_out, e.d, e.k, e.l);
                    end
                end
            end
            stalled = valid_out && !ready_out;
            prev = {data_out, keep_out, last_out};
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k,
                        input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        expq.push_back(b);
    endtask

    task automatic send_pkt(input logic [31:0] hd, input logic [3:0] hk,
                            input int nb);
        int bi = 0;
        int cyc = 0;
        bit hdone = 0;
        bit hh, hp;
        valid_insert = 1'b1;
        data_insert  = hd;
        keep_insert  = hk;
        valid_in     = 1'b1;
        data_in      = pd[0];
        keep_in      = pk[0];
        last_in      = (nb == 1);
        while (!(hdone && bi == nb)) begin
            @(negedge clk);
            hh = valid_insert && ready_insert;
            hp = valid_in && ready_in;
            @(posedge clk);
            #1;
            if (hh) begin
                hdone = 1;
                valid_insert = 1'b0;
            end
            if (hp) begin
                bi++;
                if (bi < nb) begin
                    data_in = pd[bi];
                    keep_in = pk[bi];
                    last_in = (bi == nb - 1);
                end else begin
                    valid_in = 1'b0;
                    last_in  = 1'b0;
                end
            end
            cyc++;
            if (cyc > 400) begin
                errors++;
                $display("FAIL timeout: beat %0d of %0d hdr=%0b", bi, nb, hdone);
                valid_insert = 1'b0;
                valid_in = 1'b0;
                break;
            end
        end
    endtask

    task automatic rand_pkt();
        int n  = $urandom_range(0, 4);
        int nb = $urandom_range(1, 4);
        int m  = $urandom_range(1, 4);
        logic [31:0] hd;
        logic [3:0]  hk;
        logic [31:0] d;
        logic [3:0]  k;
        logic [7:0]  q[$];
        int cnt;
        hd = $urandom;
        hk = 4'((1 << n) - 1);
        for (int j = 0; j < n; j++) q.push_back(hd[(n-1-j)*8 +: 8]);
        for (int b = 0; b < nb; b++) begin
            pd[b] = $urandom;
            pk[b] = (b == nb - 1) ? 4'(4'hF << (4 - m)) : 4'hF;
            cnt = (b == nb - 1) ? m : 4;
            for (int j = 0; j < cnt; j++) q.push_back(pd[b][31-8*j -: 8]);
        end
        while (q.size() > 0) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (q.size() > 0) begin
                    d[31-8*j -: 8] = q.pop_front();
                    k[3-j] = 1'b1;
                end
            end
            push(d, k, q.size() == 0);
        end
        send_pkt(hd, hk, nb);
    endtask

    task automatic drain();
        int cnt = 0;
        while (expq.size() > 0 && cnt < 300) begin
            @(posedge clk);
            cnt++;
        end
        chk("drain_left", 32'(expq.size()), 32'd0);
        expq.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pkt_032();
        pd[0] = 32'h11223344; pk[0] = 4'b1111;
        pd[1] = 32'h55667788; pk[1] = 4'b1100;
        push(32'hCCDD1122, 4'b1111, 1'b0);
        push(32'h33445566, 4'b1111, 1'b1);
        send_pkt(32'hAABBCCDD, 4'b0011, 2);
    endtask

    initial begin
        rst_n = 1'b0;
        #3;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_keep_out", 32'(keep_out), 32'd0);
        chk("rst_last_out", 32'(last_out), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_ready_insert", 32'(ready_insert), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        pkt_032();

        pd[0] = 32'h11223344; pk[0] = 4'b1110;
        push(32'hBBCCDD11, 4'b1111, 1'b0);
        push(32'h22330000, 4'b1100, 1'b1);
        send_pkt(32'hAABBCCDD, 4'b0111, 1);

        pd[0] = 32'h01020304; pk[0] = 4'b1111;
        pd[1] = 32'h05060708; pk[1] = 4'b1111;
        pd[2] = 32'h09000000; pk[2] = 4'b1000;
        push(32'h01020304, 4'b1111, 1'b0);
        push(32'h05060708, 4'b1111, 1'b0);
        push(32'h09000000, 4'b1000, 1'b1);
        send_pkt(32'h12345678, 4'b0000, 3);

        pd[0] = 32'hA1A2A3A4; pk[0] = 4'b1111;
        pd[1] = 32'hB1000000; pk[1] = 4'b1000;
        push(32'h0A0B0C0D, 4'b1111, 1'b0);
        push(32'hA1A2A3A4, 4'b1111, 1'b0);
        push(32'hB1000000, 4'b1000, 1'b1);
        send_pkt(32'h0A0B0C0D, 4'b1111, 2);

        pd[0] = 32'hC1C2C3C4; pk[0] = 4'b1111;
        push(32'hEEC1C2C3, 4'b1111, 1'b0);
        push(32'hC4000000, 4'b1000, 1'b1);
        send_pkt(32'h000000EE, 4'b0001, 1);

        pd[0] = 32'h44FFFFFF; pk[0] = 4'b1000;
        push(32'h11223344, 4'b1111, 1'b1);
        send_pkt(32'hFF112233, 4'b0111, 1);
        drain();

        rmode = 1;
        for (int i = 0; i < 100; i++) rand_pkt();
        drain();
        rmode = 0;
        for (int i = 0; i < 12; i++) rand_pkt();
        drain();

        rmode = 2;
        @(posedge clk);
        #2;
        valid_insert = 1'b1; data_insert = 32'h000000EE; keep_insert = 4'b0001;
        valid_in = 1'b1; data_in = 32'h01020304; keep_in = 4'hF; last_in = 1'b0;
        @(posedge clk);
        #2 valid_insert = 1'b0;
        @(posedge clk);
        #2 valid_in = 1'b0;
        chk("stall_valid_out", 32'(valid_out), 32'd1);
        chk("stall_data_out", data_out, 32'hEE010203);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid_out", 32'(valid_out), 32'd0);
        chk("arst_data_out", data_out, 32'd0);
        chk("arst_keep_out", 32'(keep_out), 32'd0);
        chk("arst_ready_in", 32'(ready_in), 32'd0);
        chk("arst_ready_insert", 32'(ready_insert), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rmode = 0;
        @(posedge clk);
        #1;
        pkt_032();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
